mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
- FSM controller for the 4-bit x 4-bit MAC datapath with a 12-bit accumulator.
- Clears the accumulator and term counter, then accepts operand pairs over a valid/ready handshake.
- Drives the register load strobes in order: operands, product, accumulate, count.
- Stops when the datapath comparator raises CMP, loads the output register and pulses done.
- Sits between the host/testbench stimulus and the datapath; it is the only driver of the datapath control inputs.

Parameters:
- CNT_W, 4, width of the count_out status input; must match the datapath counter.
- CLR_CYCLES, 1, number of cycles CLEAR holds acc_clr/count_reset asserted (1..3).

Ports:
- clk_out  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a new MAC run; sampled only in IDLE.
- abort  in  1  synchronous cancel; from any state except IDLE, go to IDLE next cycle with no ld_out.
- in_valid  in  1  operand pair a/b is present on the datapath inputs.
- in_ready  out  1  controller will capture a/b this cycle if in_valid=1.
- CMP  in  1  datapath comparator; term count has reached its terminal value.
- count_out  in  CNT_W  datapath counter value; drives status only.
- ld_a, ld_b  out  1  operand register loads.
- ld_m  out  1  product register load.
- ld_acc  out  1  accumulator load.
- ld_out  out  1  output register load.
- count_enb  out  1  counter increment enable.
- count_reset  out  1  counter synchronous clear.
- acc_clr  out  1  accumulator clear request; the top level ORs it into the accumulator clear path.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is valid on out.
- terms  out  CNT_W  registered copy of count_out, latched on done.

Behaviour:
- Reset (async, rst=1): state=IDLE; every output=0, including terms.
- All strobe outputs are Moore outputs decoded from the registered state. Exception: ld_a/ld_b = (state==WAIT_IN) & in_valid.
- IDLE: busy=0. start=1 -> CLEAR. start pulses while busy are ignored.
- CLEAR: count_reset=1 and acc_clr=1 for CLR_CYCLES cycles (internal down-counter), then -> WAIT_IN.
- WAIT_IN: in_ready=1.
  - in_valid=1: ld_a=ld_b=1 in the same cycle, -> MUL.
  - in_valid=0: hold; no timeout.
- MUL: ld_m=1 for one cycle, -> ACC.
- ACC: ld_acc=1 and count_enb=1 for one cycle, -> CHECK.
- CHECK: evaluates CMP, which reflects the already-incremented count.
  - CMP=1 -> OUT.
  - CMP=0 -> WAIT_IN.
  - Strobes are all 0 in this state.
- OUT: ld_out=1 for one cycle, -> DONE.
- DONE: done=1 and terms<=count_out, -> IDLE.
  - start high during DONE is not accepted; it must be seen again in IDLE.
- Latency:
  - start to first in_ready: 1+CLR_CYCLES cycles.
  - Per term: at least 4 cycles (WAIT_IN, MUL, ACC, CHECK) with in_valid held high.
  - Last CHECK to done: 2 cycles.
- Exactly one ld_acc and one count_enb per accepted operand pair. ld_out is never asserted without a preceding ld_acc in the same run.
- abort has priority over every other transition.
  - The abort cycle itself drives no strobes.
  - Counter and accumulator are left as-is; the next run's CLEAR cleans them.
- rst mid-run: immediate IDLE with all strobes low; datapath registers reset by the same rst.
- If CMP is already 1 in WAIT_IN, it is ignored. CMP is evaluated only in CHECK.
- Overflow: the 12-bit accumulator wraps in the datapath; the controller does not detect it.
- Encoding: binary state register, 4 bits.

Decomposition:
- Shared package mac_pkg:
  - state enum/localparams: IDLE, CLEAR, WAIT_IN, MUL, ACC, CHECK, OUT, DONE.
  - CNT_W default.
  - DATA_W=4, ACC_W=12.
- Optional sub-module mac_clr_timer: CLR_CYCLES down-counter with a `expired` output. All other logic stays in one FSM module.

Test Plan:
- Reset during ACC -> all strobes 0 within the same cycle, busy=0; the next start yields a clean run.
- start, CMP model at count 4, a=2,b=3 x4 with in_valid held -> 4 each of ld_a/ld_m/ld_acc/count_enb, one ld_out, out=24, done one cycle, terms=4, start-to-done = 2+4*4+2 cycles.
- in_valid low for 5 cycles between terms -> controller holds WAIT_IN with in_ready=1 and no other strobes; result unchanged (a=15,b=15 x4 -> out=900).
- abort asserted in MUL -> IDLE next cycle, no ld_acc/ld_out that run; a following run with a=1,b=1 x4 -> out=4.
- start pulsed while busy and during DONE -> ignored; exactly one done per accepted start.
- CLR_CYCLES=3 -> count_reset/acc_clr high exactly 3 cycles; first in_ready on cycle 4 after start.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and state codes for the MAC controller
package mac_pkg;

  localparam int DATA_W    = 4;
  localparam int ACC_W     = 12;
  localparam int CNT_W_DEF = 4;
  localparam int STATE_W   = 4;

  localparam logic [STATE_W-1:0] IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] CLEAR   = 4'd1;
  localparam logic [STATE_W-1:0] WAIT_IN = 4'd2;
  localparam logic [STATE_W-1:0] MUL     = 4'd3;
  localparam logic [STATE_W-1:0] ACC     = 4'd4;
  localparam logic [STATE_W-1:0] CHECK   = 4'd5;
  localparam logic [STATE_W-1:0] OUT     = 4'd6;
  localparam logic [STATE_W-1:0] DONE    = 4'd7;

endpackage

// File: rtl/mac_clr_timer.sv
// rtl/mac_clr_timer.sv - down-counter that sizes the CLEAR phase
module mac_clr_timer #(
  parameter int CLR_CYCLES = 1
) (
  input  logic clk_out,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [1:0] cnt;

  // Loaded with CLR_CYCLES-1 so the final CLEAR cycle is the one that sees zero.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
    end else if (load) begin
      cnt <= 2'(CLR_CYCLES - 1);
    end else if (run && (cnt != 2'd0)) begin
      cnt <= cnt - 2'd1;
    end
  end

  assign expired = run && (cnt == 2'd0);

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - control FSM sequencing the 4x4 MAC datapath loads
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int CLR_CYCLES = 1
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             CMP,
  input  logic [CNT_W-1:0] count_out,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_m,
  output logic             ld_acc,
  output logic             ld_out,
  output logic             count_enb,
  output logic             count_reset,
  output logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] terms
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               clr_expired;
  logic               live;

  mac_clr_timer #(
    .CLR_CYCLES(CLR_CYCLES)
  ) u_clr_timer (
    .clk_out (clk_out),
    .rst     (rst),
    .load    ((state == IDLE) && start),
    .run     (state == CLEAR),
    .expired (clr_expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   if (clr_expired) state_nxt = WAIT_IN;
      WAIT_IN: if (in_valid) state_nxt = MUL;
      MUL:     state_nxt = ACC;
      ACC:     state_nxt = CHECK;
      CHECK:   state_nxt = CMP ? OUT : WAIT_IN;
      OUT:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An aborting cycle must not disturb the datapath, so every strobe is masked by abort.
  assign live        = !abort;
  assign busy        = (state != IDLE);
  assign in_ready    = (state == WAIT_IN) && live;
  assign ld_a        = (state == WAIT_IN) && in_valid && live;
  assign ld_b        = (state == WAIT_IN) && in_valid && live;
  assign ld_m        = (state == MUL) && live;
  assign ld_acc      = (state == ACC) && live;
  assign count_enb   = (state == ACC) && live;
  assign count_reset = (state == CLEAR) && live;
  assign acc_clr     = (state == CLEAR) && live;
  assign ld_out      = (state == OUT) && live;
  assign done        = (state == DONE) && live;

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      terms <= '0;
    end else if ((state == DONE) && live) begin
      terms <= count_out;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - self-checking bench for mac_sequencer with a datapath model
module tb_mac_sequencer;

  logic clk_out = 1'b0;
  logic rst = 1'b1;
  always #5 clk_out = ~clk_out;

  logic start = 0, abort = 0, in_valid = 0;
  logic in_ready, cmp;
  logic ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb, count_reset, acc_clr, busy, done;
  logic [3:0] terms;

  logic [3:0]  a_in = 0, b_in = 0, ra, rb, cnt;
  logic [7:0]  rm;
  logic [11:0] acc, out_reg;
  int target = 4;

  mac_sequencer #(.CNT_W(4), .CLR_CYCLES(1)) dut (
    .clk_out(clk_out), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .CMP(cmp), .count_out(cnt),
    .ld_a(ld_a), .ld_b(ld_b), .ld_m(ld_m), .ld_acc(ld_acc), .ld_out(ld_out),
    .count_enb(count_enb), .count_reset(count_reset), .acc_clr(acc_clr),
    .busy(busy), .done(done), .terms(terms)
  );

  logic start_3 = 0, abort_3 = 0;
  logic in_ready_3, ld_a_3, ld_b_3, ld_m_3, ld_acc_3, ld_out_3, count_enb_3;
  logic count_reset_3, acc_clr_3, busy_3, done_3;
  logic [3:0] terms_3;

  mac_sequencer #(.CNT_W(4), .CLR_CYCLES(3)) dut3 (
    .clk_out(clk_out), .rst(rst), .start(start_3), .abort(abort_3),
    .in_valid(1'b0), .in_ready(in_ready_3), .CMP(1'b0), .count_out(4'd0),
    .ld_a(ld_a_3), .ld_b(ld_b_3), .ld_m(ld_m_3), .ld_acc(ld_acc_3), .ld_out(ld_out_3),
    .count_enb(count_enb_3), .count_reset(count_reset_3), .acc_clr(acc_clr_3),
    .busy(busy_3), .done(done_3), .terms(terms_3)
  );

  // Behavioural datapath the controller drives
  always @(posedge clk_out or posedge rst) begin
    if (rst) begin
      ra <= 0; rb <= 0; rm <= 0; acc <= 0; cnt <= 0; out_reg <= 0;
    end else begin
      if (ld_a) ra <= a_in;
      if (ld_b) rb <= b_in;
      if (ld_m) rm <= ra * rb;
      if (acc_clr) acc <= 0;
      else if (ld_acc) acc <= acc + {4'd0, rm};
      if (count_reset) cnt <= 0;
      else if (count_enb) cnt <= cnt + 4'd1;
      if (ld_out) out_reg <= acc;
    end
  end
  assign cmp = (int'(cnt) == target);

  int cyc = 0;
  int n_lda = 0, n_ldb = 0, n_ldm = 0, n_ldacc = 0, n_cen = 0, n_ldout = 0, n_done = 0;
  always @(posedge clk_out) begin
    cyc <= cyc + 1;
    if (!rst) begin
      n_lda   <= n_lda + int'(ld_a);
      n_ldb   <= n_ldb + int'(ld_b);
      n_ldm   <= n_ldm + int'(ld_m);
      n_ldacc <= n_ldacc + int'(ld_acc);
      n_cen   <= n_cen + int'(count_enb);
      n_ldout <= n_ldout + int'(ld_out);
      n_done  <= n_done + int'(done);
    end
  end

  int total = 0, passed = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  int opa[16], opb[16];

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk_out); t++; end
    if (t >= 100) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic do_run(input int n, input int gap, input bit poke, input int expo, input string tag);
    int s_lda = n_lda, s_ldb = n_ldb, s_ldm = n_ldm, s_acc = n_ldacc;
    int s_cen = n_cen, s_out = n_ldout, s_done = n_done;
    int c0, t, lat;
    int hold_bad = 0;
    target = n;
    @(negedge clk_out); start = 1; c0 = cyc;
    @(negedge clk_out); start = 0;
    for (int i = 0; i < n; i++) begin
      a_in = opa[i][3:0]; b_in = opb[i][3:0];
      if (gap > 0) in_valid = 0;
      wait_ready(tag);
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          if (!in_ready || ld_a || ld_b || ld_m || ld_acc || count_enb || ld_out || done)
            hold_bad++;
          if (poke && g == 0) start = 1;
          @(negedge clk_out);
          start = 0;
        end
      end
      in_valid = 1;
      @(negedge clk_out);
    end
    in_valid = 0;
    t = 0;
    while (!done && t < 200) begin @(negedge clk_out); t++; end
    chk({tag, "_done_seen"}, int'(done), 1);
    lat = cyc - c0 + 1;
    if (poke) start = 1;
    @(negedge clk_out);
    start = 0;
    chk({tag, "_done_pulse"}, int'(done), 0);
    if (poke) begin
      @(negedge clk_out);
      chk({tag, "_start_in_done_ignored"}, int'(busy), 0);
    end
    if (gap > 0) chk({tag, "_gap_hold"}, hold_bad, 0);
    chk({tag, "_out"}, int'(out_reg), expo);
    chk({tag, "_terms"}, int'(terms), n);
    chk({tag, "_n_ld_a"}, n_lda - s_lda, n);
    chk({tag, "_n_ld_b"}, n_ldb - s_ldb, n);
    chk({tag, "_n_ld_m"}, n_ldm - s_ldm, n);
    chk({tag, "_n_ld_acc"}, n_ldacc - s_acc, n);
    chk({tag, "_n_count_enb"}, n_cen - s_cen, n);
    chk({tag, "_n_ld_out"}, n_ldout - s_out, 1);
    chk({tag, "_n_done"}, n_done - s_done, 1);
    // start cycle through done cycle inclusive: (1+CLR) + 4*n + 2 with CLR=1
    if (gap == 0) chk({tag, "_latency"}, lat, 2 + 4 * n + 2);
  endtask

  typedef struct {
    int a; int b; int n; int gap; bit poke; int exp_out;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s_acc, s_out, t, first, nclr, nacl, expo, n;

    vecs[0] = '{2, 3, 4, 0, 0, 24};
    vecs[1] = '{15, 15, 4, 5, 0, 900};
    vecs[2] = '{1, 1, 4, 0, 1, 4};
    vecs[3] = '{7, 9, 3, 1, 0, 189};
    vecs[4] = '{15, 15, 15, 0, 0, 3375};
    vecs[5] = '{0, 9, 2, 2, 1, 0};

    #1;
    chk("reset_strobes", int'({in_ready, ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb,
                               count_reset, acc_clr, busy, done}), 0);
    chk("reset_terms", int'(terms), 0);
    @(negedge clk_out); @(negedge clk_out);
    rst = 0;
    @(negedge clk_out);
    chk("idle_busy", int'(busy), 0);

    // Reset landing in ACC
    target = 4;
    start = 1; @(negedge clk_out); start = 0;
    a_in = 3; b_in = 3;
    wait_ready("rst_acc");
    in_valid = 1;
    t = 0;
    while (!ld_acc && t < 20) begin @(negedge clk_out); t++; end
    chk("rst_acc_reached", int'(ld_acc), 1);
    rst = 1; #1;
    chk("rst_acc_strobes", int'({in_ready, ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb,
                                 count_reset, acc_clr, busy, done}), 0);
    in_valid = 0;
    @(negedge clk_out); rst = 0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) begin opa[i] = vecs[v].a; opb[i] = vecs[v].b; end
      do_run(vecs[v].n, vecs[v].gap, vecs[v].poke, vecs[v].exp_out, $sformatf("vec%0d", v));
    end

    // Abort in MUL, then a clean 1x1 x4 run
    s_acc = n_ldacc; s_out = n_ldout; target = 4;
    @(negedge clk_out); start = 1; @(negedge clk_out); start = 0;
    a_in = 5; b_in = 5;
    wait_ready("abort");
    in_valid = 1; @(negedge clk_out); in_valid = 0;
    chk("abort_in_mul", int'(ld_m), 1);
    abort = 1; #1;
    chk("abort_cycle_no_strobe", int'(ld_m), 0);
    @(negedge clk_out); abort = 0;
    chk("abort_idle", int'(busy), 0);
    repeat (4) @(negedge clk_out);
    chk("abort_no_ld_acc", n_ldacc - s_acc, 0);
    chk("abort_no_ld_out", n_ldout - s_out, 0);
    for (int i = 0; i < 16; i++) begin opa[i] = 1; opb[i] = 1; end
    do_run(4, 0, 0, 4, "post_abort");

    // Randomised runs against a sum-of-products reference
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 8));
      expo = 0;
      for (int i = 0; i < n; i++) begin
        opa[i] = int'($urandom_range(0, 15));
        opb[i] = int'($urandom_range(0, 15));
        expo = (expo + opa[i] * opb[i]) % 4096;
      end
      do_run(n, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), expo,
             $sformatf("rand%0d", r));
    end

    // CLR_CYCLES=3 instance
    @(negedge clk_out); start_3 = 1; t = cyc;
    @(negedge clk_out); start_3 = 0;
    nclr = 0; nacl = 0; first = -1;
    for (int k = 0; k < 8; k++) begin
      nclr += int'(count_reset_3);
      nacl += int'(acc_clr_3);
      if (in_ready_3 && first < 0) first = cyc - t;
      @(negedge clk_out);
    end
    chk("clr3_count_reset", nclr, 3);
    chk("clr3_acc_clr", nacl, 3);
    chk("clr3_first_ready", first, 4);
    abort_3 = 1; @(negedge clk_out); abort_3 = 0;
    chk("clr3_abort_idle", int'(busy_3), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
